// File: rtl/avalon_mm_pipelined_bridge_pkg.sv
// Shared types and helpers for the registered Avalon-MM bridge.
package avalon_mm_pipelined_bridge_pkg;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_e;

  localparam int unsigned BRIDGE_ADDR_W   = 32;
  localparam int unsigned BRIDGE_DATA_W   = 32;
  localparam logic [31:0] BRIDGE_ERR_DATA = 32'hDEAD_BEEF;

  // Default-width command layout; the bridge builds the same shape from its own widths.
  typedef struct packed {
    logic [BRIDGE_ADDR_W-1:0]   address;
    logic [BRIDGE_DATA_W/8-1:0] byteenable;
    logic [BRIDGE_DATA_W-1:0]   writedata;
    kind_e                      kind;
  } bridge_cmd_t;

  function automatic logic [3:0] credit_next(input logic [3:0] cur,
                                             input logic       inc,
                                             input logic       dec);
    logic [3:0] nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + 4'd1;
      2'b01:   nxt = cur - 4'd1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/avalon_mm_pipelined_bridge_tracker.sv
// Outstanding-read credit counter, read-timeout watchdog and synthetic error responses.
module avalon_read_tracker
  import avalon_mm_pipelined_bridge_pkg::*;
#(
  parameter int unsigned MAX_PENDING    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_accept,
  input  logic       m_readdatavalid,
  output logic [3:0] pending,
  output logic       credit_full,
  output logic       resp_take,
  output logic       syn_fire,
  output logic       timeout_err
);

  localparam int unsigned WD_W       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        WD_ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd;
  logic            busy;
  logic            late_drop;

  assign busy        = (pending != 4'd0);
  assign credit_full = (pending >= 4'(MAX_PENDING));
  assign resp_take   = m_readdatavalid & busy;
  assign late_drop   = m_readdatavalid & ~busy;
  // A genuine response in the firing cycle suppresses the synthetic one.
  assign syn_fire    = WD_ENABLED & busy & ~m_readdatavalid & (wd == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= '0;
    end else if (!busy || m_readdatavalid || syn_fire) begin
      wd <= '0;
    end else if (WD_ENABLED) begin
      wd <= wd + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      timeout_err <= 1'b0;
    end else begin
      pending     <= credit_next(pending, rd_accept, resp_take | syn_fire);
      timeout_err <= timeout_err | syn_fire | late_drop;
    end
  end

endmodule

// File: rtl/avalon_mm_pipelined_bridge.sv
// Registered Avalon-MM bridge: one-entry command register, pipelined reads with credits,
// registered responses and a read-timeout watchdog.
module avalon_mm_pipelined_bridge
  import avalon_mm_pipelined_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_PENDING    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = BRIDGE_ERR_DATA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [3:0]          pending_count,
  output logic                timeout_err
);

  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  typedef struct packed {
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    kind_e               kind;
  } cmd_t;

  cmd_t cmd_q;
  logic cmd_valid;
  logic up_accept;
  logic rd_accept;
  logic credit_full;
  logic resp_take;
  logic syn_fire;

  // Writes never wait on credits; only a read is held back when all slots are used.
  assign s_waitrequest = (cmd_valid & m_waitrequest) | (s_read & credit_full);
  assign up_accept     = (s_read | s_write) & ~s_waitrequest;
  assign rd_accept     = s_read & ~s_waitrequest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid <= 1'b0;
      cmd_q     <= '0;
    end else if (up_accept) begin
      cmd_valid        <= 1'b1;
      cmd_q.address    <= s_address;
      cmd_q.byteenable <= s_byteenable;
      cmd_q.writedata  <= s_writedata;
      cmd_q.kind       <= s_read ? KIND_READ : KIND_WRITE;
    end else if (cmd_valid && !m_waitrequest) begin
      cmd_valid <= 1'b0;
    end
  end

  assign m_address    = cmd_q.address;
  assign m_byteenable = cmd_q.byteenable;
  assign m_writedata  = cmd_q.writedata;
  assign m_read       = cmd_valid & (cmd_q.kind == KIND_READ);
  assign m_write      = cmd_valid & (cmd_q.kind == KIND_WRITE);

  avalon_read_tracker #(
    .MAX_PENDING   (MAX_PENDING),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .rd_accept      (rd_accept),
    .m_readdatavalid(m_readdatavalid),
    .pending        (pending_count),
    .credit_full    (credit_full),
    .resp_take      (resp_take),
    .syn_fire       (syn_fire),
    .timeout_err    (timeout_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_readdatavalid <= resp_take | syn_fire;
      if (syn_fire) begin
        s_readdata <= ERR_WORD;
      end else if (resp_take) begin
        s_readdata <= m_readdata;
      end
    end
  end

endmodule
